// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer and the single-bus datapath: instruction/status in, strobes out.
interface control_sequencer_if #(parameter int OPW = 5);
   logic [31:0]    ir;
   logic           con;
   logic           mem_ack;
   logic           Gra, Grb, Grc;
   logic           Rin, Rout, BAout;
   logic           PCout, PCin, IncPC;
   logic           MARin, MDRin, MDRout;
   logic           Read, Write;
   logic           IRin, Yin, Zin, Zlowout, Cout, CONin;
   logic [OPW-1:0] alu_op;
   logic           run;
   logic           illegal;

   modport master (
      input  ir, con, mem_ack,
      output Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC,
             MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout,
             Cout, CONin, alu_op, run, illegal
   );

   modport slave (
      output ir, con, mem_ack,
      input  Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC,
             MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout,
             Cout, CONin, alu_op, run, illegal
   );
endinterface

// File: rtl/control_sequencer.sv
// Moore control unit for the single-bus datapath: fetch F0-F2, execute E3-E7, halt until reset.
// One state per cycle; F1/E6(ld)/E7(st) stall until mem_ack is sampled high.
module control_sequencer #(
   parameter int OPW = 5
) (
   input  logic              clock,
   input  logic              reset,
   control_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      S_RST, S_F0, S_F1, S_F2, S_E3, S_E4, S_E5, S_E6, S_E7, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_JR, C_NOP, C_HALT, C_BAD
   } cls_t;

   typedef struct packed {
      logic           gra, grb, grc;
      logic           rin, rout, baout;
      logic           pcout, pcin, incpc;
      logic           marin, mdrin, mdrout;
      logic           read, write;
      logic           irin, yin, zin, zlowout, cout, conin;
      logic [OPW-1:0] alu_op;
      logic           run;
      logic           illegal;
   } ctl_t;

   localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
   localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
   localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
   localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
   localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b01011);
   localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
   localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01110);
   localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10011);
   localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10100);
   localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
   localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

   state_t         state;
   state_t         nxt;
   cls_t           cls;
   ctl_t           ctl;
   logic [OPW-1:0] op;

   function automatic cls_t classify(input logic [OPW-1:0] o);
      cls_t c;
      c = C_BAD;
      if (o >= OP_ADD && o <= OP_SHL)       c = C_ALU;
      else if (o >= OP_ADDI && o <= OP_ORI) c = C_IMM;
      else if (o == OP_LDI)                 c = C_LDI;
      else if (o == OP_LD)                  c = C_LD;
      else if (o == OP_ST)                  c = C_ST;
      else if (o == OP_BR)                  c = C_BR;
      else if (o == OP_JR)                  c = C_JR;
      else if (o == OP_NOP)                 c = C_NOP;
      else if (o == OP_HALT)                c = C_HALT;
      return c;
   endfunction

   function automatic state_t next_of(input state_t s, input cls_t c, input logic ack);
      state_t n;
      n = s;
      case (s)
         S_RST:  n = S_F0;
         S_F0:   n = S_F1;
         S_F1:   n = ack ? S_F2 : S_F1;
         S_F2:   n = S_E3;
         S_E3: begin
            case (c)
               C_HALT:             n = S_HALT;
               C_JR, C_NOP, C_BAD: n = S_F0;
               default:            n = S_E4;
            endcase
         end
         S_E4:   n = S_E5;
         S_E5:   n = (c == C_LD || c == C_ST || c == C_BR) ? S_E6 : S_F0;
         S_E6: begin
            case (c)
               C_LD:    n = ack ? S_E7 : S_E6;
               C_ST:    n = S_E7;
               default: n = S_F0;
            endcase
         end
         S_E7:   n = (c == C_ST && !ack) ? S_E7 : S_F0;
         S_HALT: n = S_HALT;
         default: n = S_RST;
      endcase
      return n;
   endfunction

   function automatic ctl_t decode(input state_t s, input cls_t c,
                                   input logic [OPW-1:0] o, input logic cn);
      ctl_t k;
      k = '0;
      k.run = (s != S_RST) && (s != S_HALT);
      case (s)
         S_F0: begin
            k.pcout = 1'b1; k.marin = 1'b1; k.incpc = 1'b1; k.zin = 1'b1;
            k.alu_op = OP_ADD;
         end
         S_F1: begin
            k.zlowout = 1'b1; k.pcin = 1'b1; k.read = 1'b1; k.mdrin = 1'b1;
         end
         S_F2: begin
            k.mdrout = 1'b1; k.irin = 1'b1;
         end
         S_E3: begin
            case (c)
               C_ALU, C_IMM: begin
                  k.grb = 1'b1; k.rout = 1'b1; k.yin = 1'b1;
               end
               C_LDI, C_LD, C_ST: begin
                  k.grb = 1'b1; k.baout = 1'b1; k.yin = 1'b1;
               end
               C_BR: begin
                  k.gra = 1'b1; k.rout = 1'b1; k.conin = 1'b1;
               end
               C_JR: begin
                  k.gra = 1'b1; k.rout = 1'b1; k.pcin = 1'b1;
               end
               C_BAD:   k.illegal = 1'b1;
               default: ;
            endcase
         end
         S_E4: begin
            case (c)
               C_ALU: begin
                  k.grc = 1'b1; k.rout = 1'b1; k.zin = 1'b1; k.alu_op = o;
               end
               C_IMM: begin
                  k.cout = 1'b1; k.zin = 1'b1; k.alu_op = o;
               end
               C_LDI, C_LD, C_ST: begin
                  k.cout = 1'b1; k.zin = 1'b1; k.alu_op = OP_ADD;
               end
               C_BR: begin
                  k.pcout = 1'b1; k.yin = 1'b1;
               end
               default: ;
            endcase
         end
         S_E5: begin
            case (c)
               C_ALU, C_IMM, C_LDI: begin
                  k.zlowout = 1'b1; k.gra = 1'b1; k.rin = 1'b1;
               end
               C_LD, C_ST: begin
                  k.zlowout = 1'b1; k.marin = 1'b1;
               end
               C_BR: begin
                  k.cout = 1'b1; k.zin = 1'b1; k.alu_op = OP_ADD;
               end
               default: ;
            endcase
         end
         S_E6: begin
            case (c)
               C_LD: begin
                  k.read = 1'b1; k.mdrin = 1'b1;
               end
               C_ST: begin
                  k.gra = 1'b1; k.rout = 1'b1; k.mdrin = 1'b1;
               end
               C_BR: begin
                  k.zlowout = 1'b1; k.pcin = cn;
               end
               default: ;
            endcase
         end
         S_E7: begin
            case (c)
               C_LD: begin
                  k.mdrout = 1'b1; k.gra = 1'b1; k.rin = 1'b1;
               end
               C_ST:    k.write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
      return k;
   endfunction

   assign op  = bus.ir[31:32-OPW];
   assign cls = classify(op);
   assign nxt = next_of(state, cls, bus.mem_ack);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_RST;
      end else begin
         state <= nxt;
      end
   end

   // Decoded from the state register rather than re-registered: IR is loaded on the
   // same edge that enters E3, so a registered decode would see the previous opcode.
   always_comb begin
      ctl = decode(state, cls, op, bus.con);
   end

   assign bus.Gra     = ctl.gra;
   assign bus.Grb     = ctl.grb;
   assign bus.Grc     = ctl.grc;
   assign bus.Rin     = ctl.rin;
   assign bus.Rout    = ctl.rout;
   assign bus.BAout   = ctl.baout;
   assign bus.PCout   = ctl.pcout;
   assign bus.PCin    = ctl.pcin;
   assign bus.IncPC   = ctl.incpc;
   assign bus.MARin   = ctl.marin;
   assign bus.MDRin   = ctl.mdrin;
   assign bus.MDRout  = ctl.mdrout;
   assign bus.Read    = ctl.read;
   assign bus.Write   = ctl.write;
   assign bus.IRin    = ctl.irin;
   assign bus.Yin     = ctl.yin;
   assign bus.Zin     = ctl.zin;
   assign bus.Zlowout = ctl.zlowout;
   assign bus.Cout    = ctl.cout;
   assign bus.CONin   = ctl.conin;
   assign bus.alu_op  = ctl.alu_op;
   assign bus.run     = ctl.run;
   assign bus.illegal = ctl.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed test-plan cases plus random instructions against a per-cycle strobe model.
module tb_control_sequencer;

   logic clock;
   logic reset;
   int   n_assert = 0;
   int   n_fail   = 0;

   control_sequencer_if bus ();

   control_sequencer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   localparam logic [26:0] GRA    = 27'd1 << 26;
   localparam logic [26:0] GRB    = 27'd1 << 25;
   localparam logic [26:0] GRC    = 27'd1 << 24;
   localparam logic [26:0] RIN    = 27'd1 << 23;
   localparam logic [26:0] ROUT   = 27'd1 << 22;
   localparam logic [26:0] BAOUT  = 27'd1 << 21;
   localparam logic [26:0] PCOUT  = 27'd1 << 20;
   localparam logic [26:0] PCIN   = 27'd1 << 19;
   localparam logic [26:0] INCPC  = 27'd1 << 18;
   localparam logic [26:0] MARIN  = 27'd1 << 17;
   localparam logic [26:0] MDRIN  = 27'd1 << 16;
   localparam logic [26:0] MDROUT = 27'd1 << 15;
   localparam logic [26:0] READ   = 27'd1 << 14;
   localparam logic [26:0] WRITE  = 27'd1 << 13;
   localparam logic [26:0] IRIN   = 27'd1 << 12;
   localparam logic [26:0] YIN    = 27'd1 << 11;
   localparam logic [26:0] ZIN    = 27'd1 << 10;
   localparam logic [26:0] ZLO    = 27'd1 << 9;
   localparam logic [26:0] COUT   = 27'd1 << 8;
   localparam logic [26:0] CONIN  = 27'd1 << 7;
   localparam logic [26:0] RUN    = 27'd1 << 1;
   localparam logic [26:0] ILL    = 27'd1 << 0;
   localparam logic [26:0] F0W    = PCOUT | MARIN | INCPC | ZIN | (27'd3 << 2) | RUN;

   logic [26:0] obs;
   assign obs = {bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout,
                 bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout,
                 bus.Read, bus.Write, bus.IRin, bus.Yin, bus.Zin, bus.Zlowout,
                 bus.Cout, bus.CONin, bus.alu_op, bus.run, bus.illegal};

   function automatic logic [26:0] aluw(input logic [4:0] x);
      return 27'(x) << 2;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Entered and left at a falling edge; async assertion is checked before any clock edge.
   task automatic do_reset(input string tag);
      #2 reset = 1'b0;
      #1 check_val({tag, ".async"}, 32'(obs), 32'd0);
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      check_val({tag, ".rst"}, 32'(obs), 32'd0);
      @(negedge clock);
      check_val({tag, ".f0"}, 32'(obs), 32'(F0W));
   endtask

   // Expected strobe word per step from the instruction tables; wait steps repeat dly+1 times.
   task automatic run_instr(input string tag, input logic [31:0] iv, input logic cv,
                            input int f1d, input int exd);
      logic [26:0] w[$];
      bit          wt[$];
      logic [4:0]  op;
      int          reps;
      op = iv[31:27];
      w.push_back(F0W);                      wt.push_back(1'b0);
      w.push_back(ZLO | PCIN | READ | MDRIN); wt.push_back(1'b1);
      w.push_back(MDROUT | IRIN);            wt.push_back(1'b0);
      if (op >= 5'd3 && op <= 5'd11) begin
         w.push_back(GRB | ROUT | YIN);             wt.push_back(1'b0);
         w.push_back(GRC | ROUT | ZIN | aluw(op));  wt.push_back(1'b0);
         w.push_back(ZLO | GRA | RIN);              wt.push_back(1'b0);
      end else if (op >= 5'd12 && op <= 5'd14) begin
         w.push_back(GRB | ROUT | YIN);             wt.push_back(1'b0);
         w.push_back(COUT | ZIN | aluw(op));        wt.push_back(1'b0);
         w.push_back(ZLO | GRA | RIN);              wt.push_back(1'b0);
      end else if (op <= 5'd2) begin
         w.push_back(GRB | BAOUT | YIN);            wt.push_back(1'b0);
         w.push_back(COUT | ZIN | aluw(5'd3));      wt.push_back(1'b0);
         if (op == 5'd1) begin
            w.push_back(ZLO | GRA | RIN);           wt.push_back(1'b0);
         end else begin
            w.push_back(ZLO | MARIN);               wt.push_back(1'b0);
            if (op == 5'd0) begin
               w.push_back(READ | MDRIN);           wt.push_back(1'b1);
               w.push_back(MDROUT | GRA | RIN);     wt.push_back(1'b0);
            end else begin
               w.push_back(GRA | ROUT | MDRIN);     wt.push_back(1'b0);
               w.push_back(WRITE);                  wt.push_back(1'b1);
            end
         end
      end else if (op == 5'd19) begin
         w.push_back(GRA | ROUT | CONIN);           wt.push_back(1'b0);
         w.push_back(PCOUT | YIN);                  wt.push_back(1'b0);
         w.push_back(COUT | ZIN | aluw(5'd3));      wt.push_back(1'b0);
         w.push_back(ZLO | (cv ? PCIN : 27'd0));    wt.push_back(1'b0);
      end else if (op == 5'd20) begin
         w.push_back(GRA | ROUT | PCIN);            wt.push_back(1'b0);
      end else if (op == 5'd26 || op == 5'd27) begin
         w.push_back(27'd0);                        wt.push_back(1'b0);
      end else begin
         w.push_back(ILL);                          wt.push_back(1'b0);
      end
      foreach (w[i]) w[i] = w[i] | RUN;
      bus.ir  = iv;
      bus.con = cv;
      foreach (w[i]) begin
         reps = wt[i] ? (((i == 1) ? f1d : exd) + 1) : 1;
         for (int r = 0; r < reps; r++) begin
            #0 check_val($sformatf("%s.s%0d", tag, i), 32'(obs), 32'(w[i]));
            bus.mem_ack = wt[i] ? (r == reps - 1) : 1'($urandom_range(0, 1));
            @(negedge clock);
         end
      end
      if (op == 5'd27) check_val({tag, ".halted"}, 32'(obs), 32'd0);
      else             check_val({tag, ".next"}, 32'(obs), 32'(F0W));
   endtask

   // Counts DUT cycles from F0 until F0 is seen again; mem_ack low for cycle indices lo..hi.
   task automatic measure_len(input string tag, input logic [31:0] iv, input logic cv,
                              input int lo, input int hi, input int explen);
      int c;
      c = 0;
      bus.ir  = iv;
      bus.con = cv;
      while (c < 60) begin
         #0;
         if (c > 0 && obs == F0W) break;
         bus.mem_ack = (c >= lo && c <= hi) ? 1'b0 : 1'b1;
         c++;
         @(negedge clock);
      end
      check_val(tag, 32'(c), 32'(explen));
   endtask

   task automatic hold_halted(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         check_val(tag, 32'(obs), 32'd0);
         bus.mem_ack = 1'($urandom_range(0, 1));
         @(negedge clock);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0]  rop;
      logic [31:0] riv;
      clock       = 1'b0;
      reset       = 1'b0;
      bus.ir      = 32'd0;
      bus.con     = 1'b0;
      bus.mem_ack = 1'b0;
      @(negedge clock);
      check_val("por", 32'(obs), 32'd0);
      do_reset("por");

      run_instr("add", 32'h1A920000, 1'b0, 0, 0);
      measure_len("add.len", 32'h1A920000, 1'b0, -1, -1, 6);
      run_instr("ld", 32'h00980055, 1'b0, 0, 2);
      measure_len("ld.len", 32'h00980055, 1'b0, 6, 7, 10);
      run_instr("br0", 32'h9B00000A, 1'b0, 0, 0);
      measure_len("br0.len", 32'h9B00000A, 1'b0, -1, -1, 7);
      run_instr("br1", 32'h9B00000A, 1'b1, 1, 0);
      measure_len("br1.len", 32'h9B00000A, 1'b1, -1, -1, 7);
      run_instr("st", 32'h10980010, 1'b0, 1, 2);
      measure_len("st.len", 32'h10980010, 1'b0, -1, -1, 8);
      run_instr("ldi", 32'h08800007, 1'b0, 0, 0);
      measure_len("jr.len", 32'hA0800000, 1'b0, -1, -1, 4);
      run_instr("ill", 32'hF8000000, 1'b0, 0, 0);
      measure_len("ill.len", 32'hF8000000, 1'b0, -1, -1, 4);

      run_instr("halt", 32'hD8000000, 1'b0, 0, 0);
      hold_halted("halt.hold", 20);
      do_reset("halt");

      bus.ir = 32'h00980055;
      for (int i = 0; i < 6; i++) begin
         bus.mem_ack = 1'b1;
         @(negedge clock);
      end
      bus.mem_ack = 1'b0;
      check_val("abort.e6", 32'(obs), 32'(READ | MDRIN | RUN));
      do_reset("abort");

      for (int n = 0; n < 40; n++) begin
         rop = 5'($urandom_range(0, 31));
         riv = {rop, 27'($urandom)};
         run_instr($sformatf("rnd%0d", n), riv, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 3));
         if (rop == 5'd27) begin
            hold_halted("rnd.halt", 3);
            do_reset("rnd.halt");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Moore-style control unit that sequences the single-bus datapath.
- Fetches each instruction through a memory handshake, then steps through execute phases.
- Drives the register select/encode stage (Gra, Grb, Grc, Rin, Rout, BAout) and all other datapath strobes.
- Holds the machine halted after a halt instruction until reset.

Parameters:
OPW, 5, opcode field width (instruction[31:27])

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
ir  in  32  current instruction register contents
con  in  1  branch condition result from CON FF logic
mem_ack  in  1  memory transfer complete
Gra, Grb, Grc  out  1 each  register field selects to select/encode stage
Rin, Rout, BAout  out  1 each  register write, read, base-address read
PCout, PCin, IncPC  out  1 each  PC strobes
MARin, MDRin, MDRout  out  1 each  MAR/MDR strobes
Read, Write  out  1 each  memory strobes; Read also steers MDR input mux
IRin, Yin, Zin, Zlowout, Cout, CONin  out  1 each  misc datapath strobes
alu_op  out  5  ALU operation code
run  out  1  high while executing
illegal  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- Reset (low, async): state=RST. Every output is 0, including run.
- RST always goes to F0 on the next edge.
- All outputs are decoded purely from state, plus ir for alu_op; there are no Mealy paths.
- run=1 in every state except RST and HALTED.
- Fetch sequence:
  - F0: PCout, MARin, IncPC, Zin.
  - F1: Zlowout, PCin, Read, MDRin. Stays in F1 until mem_ack is sampled 1; strobes are held for every cycle spent in F1.
  - F2: MDRout, IRin.
  - E3: first execute step, selected by ir[31:27].
- ALU register ops (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011):
  - E3: Grb, Rout, Yin.
  - E4: Grc, Rout, Zin, alu_op=opcode.
  - E5: Zlowout, Gra, Rin. Then F0.
- ALU immediate ops (addi 01100, andi 01101, ori 01110):
  - E3: Grb, Rout, Yin.
  - E4: Cout, Zin, alu_op=opcode.
  - E5: Zlowout, Gra, Rin. Then F0.
- ldi 00001:
  - E3: Grb, BAout, Yin.
  - E4: Cout, Zin, alu_op=00011.
  - E5: Zlowout, Gra, Rin. Then F0.
- ld 00000:
  - E3: Grb, BAout, Yin.
  - E4: Cout, Zin, alu_op=00011.
  - E5: Zlowout, MARin.
  - E6: Read, MDRin. Waits on mem_ack.
  - E7: MDRout, Gra, Rin. Then F0.
- st 00010:
  - E3 through E5 as for ld.
  - E6: Gra, Rout, MDRin, Read=0.
  - E7: Write. Waits on mem_ack. Then F0.
- br 10011:
  - E3: Gra, Rout, CONin.
  - E4: PCout, Yin.
  - E5: Cout, Zin, alu_op=00011.
  - E6: Zlowout, plus PCin only if con=1. Then F0.
- jr 10100:
  - E3: Gra, Rout, PCin. Then F0.
- nop 11010:
  - E3: no strobes. Then F0.
- halt 11011:
  - E3 goes to HALTED, with no strobes and run=0.
  - HALTED is held until reset.
- Any other opcode:
  - E3 asserts illegal for one cycle, no other strobes. Then F0.
- alu_op:
  - Is 5'b00011 in F0, even though IncPC overrides the ALU operation there.
  - Is 0 in all states not listed above.
- Wait states (F1, E6 for ld, E7 for st):
  - If mem_ack=1 on the entry cycle, the state lasts exactly one cycle.
  - mem_ack is ignored in all other states.
- Mutual exclusion, at most one asserted per cycle: Gra/Grb/Grc; Rout/BAout; Read/Write; the bus drivers (Zlowout, PCout, MDRout, Cout, Rout, BAout).
- Reset asserted mid-instruction aborts immediately to RST. The partial instruction is never retired.
- Cycle counts with immediate mem_ack: ALU and ldi 6; ld and st 8; br 7; jr and nop 4.

Test Plan:
- Reset, then hold reset high with ir=0x1A920000 (add R5,R2,R4) and mem_ack=1. Required:
  - all outputs 0 during reset;
  - F0 to E5 takes exactly 6 cycles;
  - E4: Grc=1, alu_op=00011;
  - E5: Gra=1, Rin=1;
  - then back to F0.
- ir=0x00980055 (ld R1,0x55(R3)) with mem_ack delayed 3 cycles in E6. Required:
  - E6 lasts 3 cycles, holding Read=1 and MDRin=1;
  - E7: MDRout=1, Gra=1, Rin=1;
  - total 10 cycles.
- ir=0x9B00000A (br) tested twice, con=0 and con=1. Required:
  - E6 PCin=0 with con=0;
  - E6 PCin=1 with con=1;
  - both take 7 cycles.
- ir=0xD8000000 (halt). Required:
  - run drops to 0 after E3 and stays 0 for 20 cycles;
  - reset pulse returns to RST, then F0.
- ir=0xF8000000 (opcode 11111). Required:
  - illegal=1 for exactly one cycle in E3;
  - next state F0.
- Assert reset during E6 of ld. Required: all outputs 0 immediately, without waiting for a clock edge.
